tx_buff_rd_ctrl: RTL and testbench
==================================

TX_BUFF_RD_CTRL -- requirements
Module: tx_buff_rd_ctrl

Interface
REQ-001 SHALL have parameter BW, default 9, meaning log2 of TX buffer depth in 64-bit QWs.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports trig in 1, qw_len in 13, lst_ben in 8, rsk in 1: frame-ready pulse, frame length in QWs, last-QW byte enable and cut-through-allowed flag from the frame-sync block.
REQ-005 SHALL have ports rsk_tk out 1 (cut-through ownership claim) and sync out 1 (single-cycle pulse: rd_addr sits on the next header).
REQ-006 SHALL have ports rd_addr out BW and rd_data in 64: buffer read port, registered, 1-cycle read latency.
REQ-007 SHALL have ports committed_prod in BW+1 (producer pointer) and cons out BW+1 (consumer pointer returned to the bwd logic).
REQ-008 SHALL have ports m_tdata out 64, m_tkeep out 8, m_tvalid out 1, m_tlast out 1, m_tready in 1: AXI4-Stream master to the MAC.

Function
REQ-009 SHALL keep an internal BW+1-bit read pointer rp; rd_addr = rp[BW-1:0]; all pointer arithmetic modulo 2^(BW+1).
REQ-010 SHALL treat each frame as 1 header QW (at rp) followed by qw_len data QWs; next header at rp+1+qw_len.
REQ-011 SHALL implement states IDLE, ARM, STRM, DRAIN, SYNC.
REQ-012 IDLE: on trig=1, latch qw_len/lst_ben in that cycle, set rp <= rp+1, go STRM; on trig=0 and rsk=1, assert rsk_tk, go ARM; trig has priority when both high.
REQ-013 ARM: hold rsk_tk high; latch qw_len/lst_ben on the 2nd ARM cycle, set rp <= rp+1, go STRM.
REQ-014 STRM: issue one read per cycle while the output buffer has a free slot; in cut-through (rsk_tk=1) also stall while rp == committed_prod; after the qw_len-th read go DRAIN.
REQ-015 Output buffer SHALL be a 2-entry skid so no read in flight is ever lost under m_tready=0.
REQ-016 m_tvalid SHALL stay high while the buffer is non-empty; a beat transfers on m_tvalid&m_tready; m_tdata, m_tkeep, m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-017 m_tkeep = 8'hFF on all beats except the last, which carries the latched lst_ben; m_tlast=1 only on beat qw_len.
REQ-018 DRAIN: after the last beat transfers, set cons <= rp, go SYNC.
REQ-019 SYNC: wait one cycle (header data valid), pulse sync for exactly one cycle, drop rsk_tk in the same cycle, go IDLE.
REQ-020 qw_len=0 SHALL be treated as qw_len=1 (one beat, tkeep=lst_ben).
REQ-021 trig or rsk arriving outside IDLE SHALL be ignored.
REQ-022 Buffer wrap (rd_addr from 2^BW-1 to 0) SHALL occur mid-frame with no bubble beyond m_tready stalls.
REQ-023 Throughput: with m_tready=1 and data committed, one beat per cycle, first beat 2 cycles after trig.

Reset
REQ-024 rst SHALL force state IDLE, rp=0, cons=0, rd_addr=0, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, sync=0, rsk_tk=0, skid buffer empty.
REQ-025 rst asserted mid-frame SHALL abort the frame at once with no further beats; no partial cons update.

Structure
REQ-026 FSM state encodings and the header length field position (bits 47:32) SHALL live in the shared tx package.
REQ-027 The 2-entry skid SHALL be a sub-module named tx_skid_buf; all else in tx_buff_rd_ctrl.

Verification
REQ-028 rp=0, trig with qw_len=4, lst_ben=8'h0F, m_tready=1 -> 4 beats at rd_addr 1..4, tkeep FF,FF,FF,0F, tlast on beat 4, cons=5, one sync pulse.
REQ-029 Same frame with m_tready toggling 1/0 every cycle -> identical 4 beats, no loss/duplication, data stable while stalled.
REQ-030 rp=508 (BW=9), qw_len=6 -> reads 509,510,511,0,1,2; cons=515 mod 1024; sync once.
REQ-031 Cut-through: rsk=1, trig=0, committed_prod=rp+3, qw_len=8 -> rsk_tk high, 2 beats then stall; raise committed_prod to rp+9 -> remaining 6 beats, rsk_tk drops with sync.
REQ-032 rst asserted after beat 2 of a 4-beat frame -> m_tvalid=0 next edge, cons=0, IDLE; subsequent trig frame transfers correctly.
REQ-033 trig and rsk high together in IDLE -> normal mode taken, rsk_tk stays 0.

Source files
------------

// File: rtl/tx_buff_rd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tx_buff_rd_ctrl_pkg
// Shared definitions for the TX buffer read side: read FSM state encoding,
// header length field position and the keep value used on non-final beats.
// ---------------------------------------------------------------------------
package tx_buff_rd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_STRM  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SYNC  = 3'd4
  } rd_state_t;

  // Frame length field inside the header QW.
  localparam int HDR_LEN_MSB = 47;
  localparam int HDR_LEN_LSB = 32;

  localparam logic [7:0] KEEP_ALL = 8'hFF;

  // A zero-length frame still carries one data QW.
  function automatic logic [12:0] eff_len(input logic [12:0] len);
    return (len == 13'd0) ? 13'd1 : len;
  endfunction

endpackage

// File: rtl/tx_skid_buf.sv
// ---------------------------------------------------------------------------
// tx_skid_buf
// Two-entry output buffer between the buffer read port and the AXI4-Stream
// master. The head entry drives the stream outputs directly (registered); the
// second entry absorbs a read that was already in flight when the MAC stalled.
// Ports:
//   clk, rst                      clock, async active-high reset
//   push, push_data/keep/last     beat arriving from the buffer read
//   m_tdata/m_tkeep/m_tvalid/
//   m_tlast, m_tready             AXI4-Stream master
//   count                         number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module tx_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic [7:0]  push_keep,
  input  logic        push_last,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic [1:0]  count
);

  logic [63:0] e1_data;
  logic [7:0]  e1_keep;
  logic        e1_last;
  logic        e1_valid;
  logic        pop;

  assign pop   = m_tvalid & m_tready;
  // The second entry is only ever filled while the head is occupied.
  assign count = {e1_valid, m_tvalid & ~e1_valid};

  // The caller never pushes into a full buffer, so a push without a pop
  // always finds a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
      e1_data  <= '0;
      e1_keep  <= '0;
      e1_last  <= 1'b0;
      e1_valid <= 1'b0;
    end else if (pop) begin
      if (e1_valid) begin
        m_tdata <= e1_data;
        m_tkeep <= e1_keep;
        m_tlast <= e1_last;
        if (push) begin
          e1_data <= push_data;
          e1_keep <= push_keep;
          e1_last <= push_last;
        end else begin
          e1_valid <= 1'b0;
        end
      end else if (push) begin
        m_tdata <= push_data;
        m_tkeep <= push_keep;
        m_tlast <= push_last;
      end else begin
        m_tvalid <= 1'b0;
      end
    end else if (push) begin
      if (!m_tvalid) begin
        m_tdata  <= push_data;
        m_tkeep  <= push_keep;
        m_tlast  <= push_last;
        m_tvalid <= 1'b1;
      end else begin
        e1_data  <= push_data;
        e1_keep  <= push_keep;
        e1_last  <= push_last;
        e1_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_buff_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tx_buff_rd_ctrl
// Reads frames out of the TX buffer and streams them to the MAC. Each frame
// is a header QW followed by qw_len data QWs; only the data QWs are streamed.
// In cut-through mode reads stall whenever they catch up with the producer.
// Ports:
//   clk, rst            clock, async active-high reset
//   trig, qw_len,
//   lst_ben, rsk        frame-ready pulse, length, last-QW byte enables,
//                       cut-through-allowed flag
//   rsk_tk              cut-through ownership claim
//   sync                one-cycle pulse: rd_addr points at the next header
//   rd_addr, rd_data    buffer read port (1-cycle latency)
//   committed_prod      producer pointer
//   cons                consumer pointer handed back once a frame is done
//   m_t*                AXI4-Stream master
// ---------------------------------------------------------------------------
module tx_buff_rd_ctrl
  import tx_buff_rd_ctrl_pkg::*;
#(
  parameter int BW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic [12:0]   qw_len,
  input  logic [7:0]    lst_ben,
  input  logic          rsk,
  output logic          rsk_tk,
  output logic          sync,
  output logic [BW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  input  logic [BW:0]   committed_prod,
  output logic [BW:0]   cons,
  output logic [63:0]   m_tdata,
  output logic [7:0]    m_tkeep,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready
);

  rd_state_t   state;
  logic [BW:0] rp;
  logic [12:0] len_q;
  logic [7:0]  ben_q;
  logic [12:0] rd_cnt;
  logic        arm_wait;
  logic        sync_wait;
  logic        rd_vld;
  logic [7:0]  rd_keep;
  logic        rd_last;

  logic [1:0]  skid_count;
  logic        pop;
  logic [2:0]  occ;
  logic        room;
  logic        ct_block;
  logic        issue;
  logic        issue_last;

  assign rd_addr = rp[BW-1:0];
  assign pop     = m_tvalid & m_tready;

  // Entries held plus the read in flight, minus the beat leaving this cycle,
  // must leave a slot for the new read when it lands next cycle.
  always_comb begin
    occ        = 3'(skid_count) + 3'(rd_vld) - 3'(pop);
    room       = (occ < 3'd2);
    ct_block   = rsk_tk && (rp == committed_prod);
    issue      = (state == ST_STRM) && room && !ct_block;
    issue_last = ((rd_cnt + 13'd1) == len_q);
  end

  // Single FSM: frame setup, one read per cycle while there is room, wait for
  // the final beat to leave, then let the header read settle before sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rp        <= '0;
      cons      <= '0;
      len_q     <= '0;
      ben_q     <= '0;
      rd_cnt    <= '0;
      arm_wait  <= 1'b0;
      sync_wait <= 1'b0;
      rd_vld    <= 1'b0;
      rd_keep   <= '0;
      rd_last   <= 1'b0;
      sync      <= 1'b0;
      rsk_tk    <= 1'b0;
    end else begin
      sync   <= 1'b0;
      rd_vld <= issue;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            len_q  <= eff_len(qw_len);
            ben_q  <= lst_ben;
            rd_cnt <= '0;
            rp     <= rp + 1'b1;
            state  <= ST_STRM;
          end else if (rsk) begin
            rsk_tk   <= 1'b1;
            arm_wait <= 1'b0;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (!arm_wait) begin
            arm_wait <= 1'b1;
          end else begin
            len_q  <= eff_len(qw_len);
            ben_q  <= lst_ben;
            rd_cnt <= '0;
            rp     <= rp + 1'b1;
            state  <= ST_STRM;
          end
        end
        ST_STRM: begin
          if (issue) begin
            rp      <= rp + 1'b1;
            rd_cnt  <= rd_cnt + 13'd1;
            rd_last <= issue_last;
            rd_keep <= issue_last ? ben_q : KEEP_ALL;
            if (issue_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && m_tlast) begin
            cons      <= rp;
            sync_wait <= 1'b0;
            state     <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (!sync_wait) begin
            sync_wait <= 1'b1;
          end else begin
            sync   <= 1'b1;
            rsk_tk <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_vld),
    .push_data(rd_data),
    .push_keep(rd_keep),
    .push_last(rd_last),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .count    (skid_count)
  );

endmodule

// File: tb/tb_tx_buff_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_buff_rd_ctrl
// Bench for tx_buff_rd_ctrl. A buffer memory model serves the read port; the
// expected beats of each frame are computed from the header pointer and
// length and checked by one compare process on every handshake.
// ---------------------------------------------------------------------------
module tb_tx_buff_rd_ctrl;

  localparam int BW    = 9;
  localparam int DEPTH = 1 << BW;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          trig;
  logic [12:0]   qw_len;
  logic [7:0]    lst_ben;
  logic          rsk;
  logic          rsk_tk;
  logic          sync;
  logic [BW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [BW:0]   committed_prod;
  logic [BW:0]   cons;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;

  logic [63:0] mem [DEPTH];
  beat_t       exp_q [$];
  logic [7:0]  cap_keep [$];
  logic        cap_last [$];
  int          cap_cyc [$];

  int          checks;
  int          errors;
  int          cyc;
  int          sync_cnt;
  int          first_vld;
  int          start_cyc;
  bit          rsk_seen;
  bit          prev_stall;
  logic [72:0] prev_beat;
  logic [BW:0] model_rp;
  logic [BW:0] model_next;

  tx_buff_rd_ctrl #(.BW(BW)) dut (
    .clk           (clk),
    .rst           (rst),
    .trig          (trig),
    .qw_len        (qw_len),
    .lst_ben       (lst_ben),
    .rsk           (rsk),
    .rsk_tk        (rsk_tk),
    .sync          (sync),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .committed_prod(committed_prod),
    .cons          (cons),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered buffer read, one cycle of latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: every transferred beat against the model, plus hold
  // checks on every stalled cycle.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        checkOutput("stall_hold", {63'd0, m_tvalid} << 0 | 64'({m_tdata, m_tkeep, m_tlast} != prev_beat) << 1,
                    64'd1);
      if (sync) sync_cnt++;
      if (rsk_tk) rsk_seen = 1'b1;
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", m_tdata, e.d);
          checkOutput("beat_keep", 64'(m_tkeep), 64'(e.k));
          checkOutput("beat_last", 64'(m_tlast), 64'(e.l));
        end
        cap_keep.push_back(m_tkeep);
        cap_last.push_back(m_tlast);
        cap_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tkeep, m_tlast};
    end
  end

  task automatic tick(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Builds the expected beats, presents the frame, then waits for sync and
  // checks pointer return, the single sync pulse and ownership.
  task automatic applyStimulus(input int len, input logic [7:0] ben,
                               input bit cut, input bit both, input int mode,
                               input bit noise, input int stall_at,
                               input int stall_cycles, input bit check_stall);
    int          eff;
    int          base;
    int          n;
    int          budget;
    logic [BW:0] a;
    beat_t       b;
    eff        = (len == 0) ? 1 : len;
    model_next = model_rp + (BW+1)'(1 + eff);
    base       = sync_cnt;
    rsk_seen   = 1'b0;
    first_vld  = -1;
    cap_keep.delete();
    cap_last.delete();
    cap_cyc.delete();
    for (int i = 1; i <= eff; i++) begin
      a   = model_rp + (BW+1)'(i);
      b.d = mem[a[BW-1:0]];
      b.l = (i == eff);
      b.k = (i == eff) ? ben : 8'hFF;
      exp_q.push_back(b);
    end
    committed_prod = (cut && !both) ? model_rp + (BW+1)'(1 + stall_at) : model_rp;
    tick(mode);
    trig    = !cut || both;
    rsk     = cut || both;
    qw_len  = 13'(len);
    lst_ben = ben;
    tick(mode);
    start_cyc = cyc;
    trig = 1'b0;
    rsk  = 1'b0;
    tick(mode);
    tick(mode);
    qw_len  = 13'($urandom);
    lst_ben = 8'($urandom);
    n      = 0;
    budget = 200 + eff * 8 + stall_cycles;
    while (sync_cnt == base && n < budget) begin
      tick(mode);
      n++;
      if (noise && exp_q.size() > 0) begin
        trig   = ($urandom_range(0, 3) == 0);
        rsk    = ($urandom_range(0, 3) == 0);
        qw_len = 13'($urandom);
      end else begin
        trig = 1'b0;
        rsk  = 1'b0;
      end
      if (cut && !both && n == stall_cycles) begin
        if (check_stall) begin
          checkOutput("ct_beats", 64'(eff - exp_q.size()), 64'(stall_at));
          checkOutput("ct_rsk_tk", 64'(rsk_tk), 64'd1);
        end
        committed_prod = model_next;
      end
    end
    trig = 1'b0;
    rsk  = 1'b0;
    if (sync_cnt == base) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout actual=no_sync required=sync len=%0d", len);
    end
    tick(mode);
    tick(mode);
    tick(mode);
    checkOutput("sync_pulses", 64'(sync_cnt - base), 64'd1);
    checkOutput("cons", 64'(cons), 64'(model_next));
    checkOutput("beats_left", 64'(exp_q.size()), 64'd0);
    checkOutput("rsk_tk_mode", 64'(rsk_seen), 64'(cut && !both));
    checkOutput("rsk_tk_end", 64'(rsk_tk), 64'd0);
    exp_q.delete();
    model_rp = model_next;
  endtask

  initial begin
    int len;
    int eff;
    bit cut;
    bit both;
    int w;
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    sync_cnt       = 0;
    first_vld      = -1;
    prev_stall     = 1'b0;
    model_rp       = '0;
    trig           = 1'b0;
    rsk            = 1'b0;
    qw_len         = '0;
    lst_ben        = '0;
    m_tready       = 1'b1;
    committed_prod = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_outs", {m_tdata}, 64'd0);
    checkOutput("rst_misc", 64'({m_tkeep, m_tlast, sync, rsk_tk}), 64'd0);
    checkOutput("rst_ptrs", 64'({cons, rd_addr}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic 4-beat frame from rp=0.
    applyStimulus(4, 8'h0F, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("f1_cons", 64'(cons), 64'd5);
    checkOutput("f1_nbeats", 64'(cap_keep.size()), 64'd4);
    if (cap_keep.size() == 4) begin
      checkOutput("f1_keep0", 64'(cap_keep[0]), 64'hFF);
      checkOutput("f1_keep2", 64'(cap_keep[2]), 64'hFF);
      checkOutput("f1_keep3", 64'(cap_keep[3]), 64'h0F);
      checkOutput("f1_last", 64'({cap_last[0], cap_last[1], cap_last[2], cap_last[3]}), 64'b0001);
      checkOutput("f1_burst", 64'(cap_cyc[3] - cap_cyc[0]), 64'd3);
    end
    checkOutput("f1_latency", 64'(first_vld - start_cyc), 64'd2);

    // Same frame with m_tready toggling.
    applyStimulus(4, 8'h0F, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("f2_cons", 64'(cons), 64'd10);
    checkOutput("f2_nbeats", 64'(cap_keep.size()), 64'd4);

    // Walk rp up to 508, then a frame across the buffer wrap.
    applyStimulus(497, 8'h3C, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("walk_cons", 64'(cons), 64'd508);
    applyStimulus(6, 8'h01, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_cons", 64'(cons), 64'd515);
    if (cap_cyc.size() == 6)
      checkOutput("wrap_burst", 64'(cap_cyc[5] - cap_cyc[0]), 64'd5);
    else
      checkOutput("wrap_nbeats", 64'(cap_cyc.size()), 64'd6);

    // Cut-through: producer only 2 QWs ahead, then released.
    applyStimulus(8, 8'h7F, 1, 0, 0, 0, 2, 20, 1);
    checkOutput("ct_cons", 64'(cons), 64'd524);

    // Reset after beat 2 of a 4-beat frame.
    begin
      beat_t       b;
      logic [BW:0] a;
      for (int i = 1; i <= 4; i++) begin
        a   = model_rp + (BW+1)'(i);
        b.d = mem[a[BW-1:0]];
        b.l = (i == 4);
        b.k = (i == 4) ? 8'hAA : 8'hFF;
        exp_q.push_back(b);
      end
      tick(0);
      trig    = 1'b1;
      qw_len  = 13'd4;
      lst_ben = 8'hAA;
      tick(0);
      trig = 1'b0;
      w = 0;
      while (exp_q.size() > 2 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (exp_q.size() > 2) begin
        checks++;
        errors++;
        $display("[TB] FAIL rst_wait actual=%0d required=2", exp_q.size());
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("midrst_cons", 64'(cons), 64'd0);
      checkOutput("midrst_addr", 64'(rd_addr), 64'd0);
      exp_q.delete();
      model_rp = '0;
      @(posedge clk);
      #1 rst = 1'b0;
    end
    applyStimulus(3, 8'hC3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postrst_cons", 64'(cons), 64'd4);

    // trig and rsk together: normal mode wins.
    applyStimulus(2, 8'h11, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("both_cons", 64'(cons), 64'd7);

    // Zero length behaves as one beat.
    applyStimulus(0, 8'h5A, 0, 0, 2, 0, 0, 0, 0);
    checkOutput("zero_cons", 64'(cons), 64'd9);
    checkOutput("zero_nbeats", 64'(cap_keep.size()), 64'd1);
    if (cap_keep.size() == 1)
      checkOutput("zero_beat", 64'({cap_keep[0], cap_last[0]}), 64'({8'h5A, 1'b1}));

    // Randomized frames with stray trig/rsk during the frame.
    for (int f = 0; f < 25; f++) begin
      len  = $urandom_range(0, 20);
      eff  = (len == 0) ? 1 : len;
      cut  = ($urandom_range(0, 2) == 0);
      both = !cut && ($urandom_range(0, 4) == 0);
      applyStimulus(len, 8'($urandom), cut || both, both, $urandom_range(0, 2), 1,
                    $urandom_range(0, eff), $urandom_range(1, 15), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
